tile_miss_collect: RTL and testbench

Per-tile miss collector sitting directly upstream of the tile XY cluster FIFO. It takes up to three line-miss requests per cycle from the tile's cache ports and merges duplicates, both within a cycle and against misses already outstanding. It then issues only new misses on the `missue_en/addr/phy` bus that the cluster FIFO consumes, and holds each miss in an entry table until the matching fill returns from the mesh.

---
 rtl/tile_miss_collect_if.sv | 29 ++
 rtl/tile_miss_collect.sv | 157 +++++++++++++++
 tb/tb_tile_miss_collect.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tile_miss_collect_if.sv
// Request, issue, fill and status signals between the tile cache ports,
// the miss collector and the cluster FIFO / mesh return path.
interface tile_miss_collect_if;
    logic [2:0]       req_en;
    logic [2:0][38:0] req_addr;
    logic [2:0][39:0] req_phy;
    logic             req_ready;
    logic [2:0]       missue_en;
    logic [2:0][38:0] missue_addr;
    logic [2:0][39:0] missue_phy;
    logic             fill_en;
    logic [38:0]      fill_addr;
    logic             wake_en;
    logic [38:0]      wake_addr;
    logic             fill_orphan;
    logic [4:0]       miss_cnt;

    modport master (
        output req_en, req_addr, req_phy, fill_en, fill_addr,
        input  req_ready, missue_en, missue_addr, missue_phy,
               wake_en, wake_addr, fill_orphan, miss_cnt
    );

    modport slave (
        input  req_en, req_addr, req_phy, fill_en, fill_addr,
        output req_ready, missue_en, missue_addr, missue_phy,
               wake_en, wake_addr, fill_orphan, miss_cnt
    );
endinterface

// File: rtl/tile_miss_collect.sv
// Per-tile miss collector: merges duplicate line misses against each other and
// the outstanding table, issues only new ones, and retires entries on fill.
module tile_miss_collect #(
    parameter int ENTRIES   = 8,
    parameter int READY_MIN = 3
) (
    input logic               clk,
    input logic               rst,
    tile_miss_collect_if.slave bus
);

    logic [ENTRIES-1:0] valid;
    logic [38:0]        ent_addr [ENTRIES];
    logic [39:0]        ent_phy  [ENTRIES];

    logic               ready_q;
    logic [2:0]         iss_en_q;
    logic [2:0][38:0]   iss_addr_q;
    logic [2:0][39:0]   iss_phy_q;
    logic               wake_en_q;
    logic [38:0]        wake_addr_q;
    logic               orphan_q;
    logic [4:0]         cnt_q;

    logic [2:0]         hit;
    logic [2:0]         dup;
    logic [2:0]         is_new;
    logic [2:0]         take;
    logic               overflow;
    logic               found;
    logic [ENTRIES-1:0] free_left;
    logic [ENTRIES-1:0] alloc_oh [3];
    logic [ENTRIES-1:0] alloc_mask;
    logic [ENTRIES-1:0] fill_match;
    logic [ENTRIES-1:0] valid_nxt;
    logic [4:0]         cnt_nxt;
    logic [1:0]         take_cnt;
    logic [1:0]         slot;
    logic [2:0]         iss_en_d;
    logic [2:0][38:0]   iss_addr_d;
    logic [2:0][39:0]   iss_phy_d;

    function automatic logic [4:0] popcnt(input logic [ENTRIES-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < ENTRIES; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    // Merge and allocation decisions look only at start-of-cycle table state.
    always_comb begin
        hit        = '0;
        dup        = '0;
        is_new     = '0;
        overflow   = 1'b0;
        found      = 1'b0;
        free_left  = ~valid;
        alloc_mask = '0;
        for (int p = 0; p < 3; p++) alloc_oh[p] = '0;

        for (int p = 0; p < 3; p++) begin
            for (int e = 0; e < ENTRIES; e++)
                if (valid[e] && ent_addr[e] == bus.req_addr[p]) hit[p] = 1'b1;
            for (int q = 0; q < p; q++)
                if (bus.req_en[q] && bus.req_addr[q] == bus.req_addr[p]) dup[p] = 1'b1;
            is_new[p] = ready_q && bus.req_en[p] && !dup[p] && !hit[p];
            if (is_new[p]) begin
                found = 1'b0;
                for (int e = 0; e < ENTRIES; e++) begin
                    if (!found && free_left[e]) begin
                        alloc_oh[p][e] = 1'b1;
                        free_left[e]   = 1'b0;
                        found          = 1'b1;
                    end
                end
                if (!found) overflow = 1'b1;
            end
        end

        // A short table drops the whole cycle rather than a partial subset.
        if (overflow) begin
            for (int p = 0; p < 3; p++) alloc_oh[p] = '0;
        end
        for (int p = 0; p < 3; p++) alloc_mask = alloc_mask | alloc_oh[p];
        take = overflow ? 3'b000 : is_new;
    end

    always_comb begin
        for (int e = 0; e < ENTRIES; e++)
            fill_match[e] = bus.fill_en && valid[e] && ent_addr[e] == bus.fill_addr;
        valid_nxt = (valid & ~fill_match) | alloc_mask;
        cnt_nxt   = popcnt(valid_nxt);
    end

    always_comb begin
        iss_addr_d = '0;
        iss_phy_d  = '0;
        slot       = '0;
        for (int p = 0; p < 3; p++) begin
            if (take[p]) begin
                iss_addr_d[slot] = bus.req_addr[p];
                iss_phy_d[slot]  = bus.req_phy[p];
                slot             = slot + 2'd1;
            end
        end
        take_cnt = 2'(take[0]) + 2'(take[1]) + 2'(take[2]);
        iss_en_d = 3'((4'd1 << take_cnt) - 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            ready_q     <= 1'b1;
            iss_en_q    <= '0;
            iss_addr_q  <= '0;
            iss_phy_q   <= '0;
            wake_en_q   <= 1'b0;
            wake_addr_q <= '0;
            orphan_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            valid       <= valid_nxt;
            ready_q     <= (5'(ENTRIES) - cnt_nxt) >= 5'(READY_MIN);
            iss_en_q    <= iss_en_d;
            iss_addr_q  <= iss_addr_d;
            iss_phy_q   <= iss_phy_d;
            wake_en_q   <= |fill_match;
            wake_addr_q <= (|fill_match) ? bus.fill_addr : '0;
            orphan_q    <= bus.fill_en && !(|fill_match);
            cnt_q       <= cnt_nxt;
        end
    end

    // Entry payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int e = 0; e < ENTRIES; e++) begin
            for (int p = 0; p < 3; p++) begin
                if (alloc_oh[p][e]) begin
                    ent_addr[e] <= bus.req_addr[p];
                    ent_phy[e]  <= bus.req_phy[p];
                end
            end
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.missue_en   = iss_en_q;
    assign bus.missue_addr = iss_addr_q;
    assign bus.missue_phy  = iss_phy_q;
    assign bus.wake_en     = wake_en_q;
    assign bus.wake_addr   = wake_addr_q;
    assign bus.fill_orphan = orphan_q;
    assign bus.miss_cnt    = cnt_q;

    overflow_guard: assert property (@(posedge clk) disable iff (rst) !overflow);

endmodule

// File: tb/tb_tile_miss_collect.sv
// Bench for tile_miss_collect: directed scenarios plus a randomized run
// checked against a set-based model of the outstanding misses.
module tb_tile_miss_collect;
    localparam int ENTRIES   = 8;
    localparam int READY_MIN = 3;

    logic clk;
    logic rst;
    tile_miss_collect_if bus ();

    tile_miss_collect #(.ENTRIES(ENTRIES), .READY_MIN(READY_MIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the set of outstanding line addresses.
    bit               tab [logic [38:0]];
    logic [2:0]       exp_en;
    logic [2:0][38:0] exp_addr;
    logic [2:0][39:0] exp_phy;
    logic             exp_wake;
    logic [38:0]      exp_wake_addr;
    logic             exp_orph;
    logic [4:0]       exp_cnt;
    logic             exp_ready = 1'b1;

    function automatic void model_cycle();
        logic [38:0] seen [$];
        logic [38:0] na [$];
        logic [39:0] np [$];
        exp_en = '0; exp_addr = '0; exp_phy = '0;
        exp_wake = 1'b0; exp_wake_addr = '0; exp_orph = 1'b0;
        if (rst) begin
            tab.delete();
            exp_cnt = '0;
            exp_ready = 1'b1;
            return;
        end
        if (exp_ready) begin
            for (int p = 0; p < 3; p++) begin
                if (bus.req_en[p]) begin
                    bit d = 1'b0;
                    foreach (seen[i]) if (seen[i] == bus.req_addr[p]) d = 1'b1;
                    if (!d && !tab.exists(bus.req_addr[p])) begin
                        na.push_back(bus.req_addr[p]);
                        np.push_back(bus.req_phy[p]);
                    end
                    seen.push_back(bus.req_addr[p]);
                end
            end
        end
        if (bus.fill_en) begin
            if (tab.exists(bus.fill_addr)) begin
                tab.delete(bus.fill_addr);
                exp_wake = 1'b1;
                exp_wake_addr = bus.fill_addr;
            end else begin
                exp_orph = 1'b1;
            end
        end
        foreach (na[i]) begin
            tab[na[i]] = 1'b1;
            exp_en[i] = 1'b1;
            exp_addr[i] = na[i];
            exp_phy[i] = np[i];
        end
        exp_cnt = 5'(tab.num());
        exp_ready = (ENTRIES - tab.num()) >= READY_MIN;
    endfunction

    task automatic idle_inputs();
        bus.req_en = '0; bus.req_addr = '0; bus.req_phy = '0;
        bus.fill_en = 1'b0; bus.fill_addr = '0;
    endtask

    task automatic cycle();
        model_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic req3(input logic [2:0] en, input logic [38:0] a0, input logic [38:0] a1,
                        input logic [38:0] a2);
        bus.req_en = en;
        bus.req_addr[0] = a0; bus.req_addr[1] = a1; bus.req_addr[2] = a2;
        bus.req_phy[0] = {1'b0, a0} ^ 40'hA5; bus.req_phy[1] = {1'b0, a1} ^ 40'h5A;
        bus.req_phy[2] = {1'b0, a2} ^ 40'h3C;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        n_cmp++; if (bus.missue_en !== 3'b000) begin n_bad++; $display("FAIL reset_missue_en got %b want 000", bus.missue_en); end
        n_cmp++; if (bus.missue_addr !== '0 || bus.missue_phy !== '0) begin n_bad++; $display("FAIL reset_missue_data got %h/%h want 0", bus.missue_addr, bus.missue_phy); end
        n_cmp++; if (bus.wake_en !== 1'b0 || bus.wake_addr !== '0 || bus.fill_orphan !== 1'b0) begin n_bad++; $display("FAIL reset_wake got %b/%h/%b want 0/0/0", bus.wake_en, bus.wake_addr, bus.fill_orphan); end
        n_cmp++; if (bus.miss_cnt !== 5'd0 || bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_status got cnt %0d ready %b want 0/1", bus.miss_cnt, bus.req_ready); end
    endtask

    task automatic test_issue_order();
        do_reset();
        req3(3'b111, 39'h100, 39'h200, 39'h300);
        cycle();
        n_cmp++; if (bus.missue_en !== 3'b111) begin n_bad++; $display("FAIL order_en got %b want 111", bus.missue_en); end
        n_cmp++; if (bus.missue_addr !== {39'h300, 39'h200, 39'h100}) begin n_bad++; $display("FAIL order_addr got %h want 300/200/100", bus.missue_addr); end
        n_cmp++; if (bus.missue_phy[1] !== 40'h25A) begin n_bad++; $display("FAIL order_phy1 got %h want 25a", bus.missue_phy[1]); end
        n_cmp++; if (bus.miss_cnt !== 5'd3) begin n_bad++; $display("FAIL order_cnt got %0d want 3", bus.miss_cnt); end
    endtask

    task automatic test_merge_and_fill();
        do_reset();
        req3(3'b111, 39'h100, 39'h100, 39'h240);
        cycle();
        n_cmp++; if (bus.missue_en !== 3'b011) begin n_bad++; $display("FAIL merge_en got %b want 011", bus.missue_en); end
        n_cmp++; if (bus.missue_addr !== {39'h0, 39'h240, 39'h100}) begin n_bad++; $display("FAIL merge_addr got %h want 0/240/100", bus.missue_addr); end
        n_cmp++; if (bus.missue_phy[2] !== 40'h0) begin n_bad++; $display("FAIL merge_unused_phy got %h want 0", bus.missue_phy[2]); end
        req3(3'b001, 39'h100, 39'h0, 39'h0);
        cycle();
        n_cmp++; if (bus.missue_en !== 3'b000 || bus.miss_cnt !== 5'd2) begin n_bad++; $display("FAIL rereq got en %b cnt %0d want 000/2", bus.missue_en, bus.miss_cnt); end
        req3(3'b001, 39'h100, 39'h0, 39'h0);
        bus.fill_en = 1'b1; bus.fill_addr = 39'h100;
        cycle();
        n_cmp++; if (bus.missue_en !== 3'b000) begin n_bad++; $display("FAIL samefill_en got %b want 000", bus.missue_en); end
        n_cmp++; if (bus.wake_en !== 1'b1 || bus.wake_addr !== 39'h100) begin n_bad++; $display("FAIL samefill_wake got %b/%h want 1/100", bus.wake_en, bus.wake_addr); end
        n_cmp++; if (bus.miss_cnt !== 5'd1 || bus.fill_orphan !== 1'b0) begin n_bad++; $display("FAIL samefill_cnt got %0d orphan %b want 1/0", bus.miss_cnt, bus.fill_orphan); end
    endtask

    task automatic test_ready();
        do_reset();
        req3(3'b111, 39'h10, 39'h20, 39'h30);
        cycle();
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after3 got %b want 1", bus.req_ready); end
        req3(3'b111, 39'h40, 39'h50, 39'h60);
        cycle();
        n_cmp++; if (bus.req_ready !== 1'b0 || bus.miss_cnt !== 5'd6) begin n_bad++; $display("FAIL ready_after6 got %b cnt %0d want 0/6", bus.req_ready, bus.miss_cnt); end
        req3(3'b011, 39'h70, 39'h10, 39'h0);
        cycle();
        n_cmp++; if (bus.missue_en !== 3'b000 || bus.miss_cnt !== 5'd6) begin n_bad++; $display("FAIL ignored_req got en %b cnt %0d want 000/6", bus.missue_en, bus.miss_cnt); end
        bus.fill_en = 1'b1; bus.fill_addr = 39'h10;
        cycle();
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.miss_cnt !== 5'd5) begin n_bad++; $display("FAIL ready_rise got %b cnt %0d want 1/5", bus.req_ready, bus.miss_cnt); end
        req3(3'b001, 39'h70, 39'h0, 39'h0);
        cycle();
        n_cmp++; if (bus.missue_en !== 3'b001 || bus.missue_addr[0] !== 39'h70) begin n_bad++; $display("FAIL after_ready got %b/%h want 001/70", bus.missue_en, bus.missue_addr[0]); end
    endtask

    task automatic test_orphan();
        do_reset();
        req3(3'b001, 39'h123, 39'h0, 39'h0);
        cycle();
        bus.fill_en = 1'b1; bus.fill_addr = 39'h7F0;
        cycle();
        n_cmp++; if (bus.fill_orphan !== 1'b1 || bus.wake_en !== 1'b0) begin n_bad++; $display("FAIL orphan got %b wake %b want 1/0", bus.fill_orphan, bus.wake_en); end
        n_cmp++; if (bus.miss_cnt !== 5'd1) begin n_bad++; $display("FAIL orphan_cnt got %0d want 1", bus.miss_cnt); end
        cycle();
        n_cmp++; if (bus.fill_orphan !== 1'b0) begin n_bad++; $display("FAIL orphan_pulse got %b want 0", bus.fill_orphan); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req3(3'b111, 39'h400, 39'h500, 39'h600);
        cycle();
        req3(3'b001, 39'h700, 39'h0, 39'h0);
        cycle();
        n_cmp++; if (bus.miss_cnt !== 5'd4) begin n_bad++; $display("FAIL mid_cnt got %0d want 4", bus.miss_cnt); end
        rst = 1'b1;
        req3(3'b001, 39'h800, 39'h0, 39'h0);
        cycle();
        rst = 1'b0;
        n_cmp++; if (bus.miss_cnt !== 5'd0 || bus.missue_en !== 3'b000 || bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset got cnt %0d en %b ready %b want 0/000/1", bus.miss_cnt, bus.missue_en, bus.req_ready); end
        bus.fill_en = 1'b1; bus.fill_addr = 39'h500;
        cycle();
        n_cmp++; if (bus.fill_orphan !== 1'b1 || bus.wake_en !== 1'b0) begin n_bad++; $display("FAIL mid_orphan got %b wake %b want 1/0", bus.fill_orphan, bus.wake_en); end
    endtask

    task automatic test_random();
        logic [38:0] pool [10];
        for (int i = 0; i < 10; i++) pool[i] = {7'($urandom), 32'($urandom)};
        pool[7] = pool[0] ^ (39'd1 << 38);
        pool[6] = pool[1] ^ 39'd1;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.req_en = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                bus.req_addr[p] = pool[$urandom_range(0, 9)];
                bus.req_phy[p] = {8'($urandom), 32'($urandom)};
            end
            bus.fill_en = 1'($urandom_range(0, 1));
            bus.fill_addr = pool[$urandom_range(0, 9)];
            cycle();
            rst = 1'b0;
            n_cmp++; if (bus.missue_en !== exp_en || bus.missue_addr !== exp_addr || bus.missue_phy !== exp_phy) begin
                n_bad++; $display("FAIL rnd_issue c%0d got %b %h want %b %h", c, bus.missue_en, bus.missue_addr, exp_en, exp_addr);
            end
            n_cmp++; if (bus.wake_en !== exp_wake || bus.fill_orphan !== exp_orph || (exp_wake && bus.wake_addr !== exp_wake_addr)) begin
                n_bad++; $display("FAIL rnd_fill c%0d got %b/%b/%h want %b/%b/%h", c, bus.wake_en, bus.fill_orphan, bus.wake_addr, exp_wake, exp_orph, exp_wake_addr);
            end
            n_cmp++; if (bus.miss_cnt !== exp_cnt || bus.req_ready !== exp_ready) begin
                n_bad++; $display("FAIL rnd_status c%0d got cnt %0d ready %b want %0d/%b", c, bus.miss_cnt, bus.req_ready, exp_cnt, exp_ready);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_issue_order();
        test_merge_and_fill();
        test_ready();
        test_orphan();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
